// File: rtl/xalu_if.sv
// E-stage XALU bus: operation/operands in, HI/LO, readback and busy/stall indications out.
interface xalu_if;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        start;
   logic        busy;
   logic        stall_busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] out;

   modport master (
      output op, A, B,
      input  start, busy, stall_busy, HI, LO, out
   );

   modport slave (
      input  op, A, B,
      output start, busy, stall_busy, HI, LO, out
   );
endinterface

// File: rtl/xalu.sv
// Multi-cycle multiply/divide unit owning HI/LO; results are held in pending registers
// and committed only at the end of the busy window.
module xalu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic    clk,
   input  logic    reset,
   xalu_if.slave   x
);
   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      phi_q, phi_d, plo_q, plo_d;

   // Arithmetic datapath; zero divisors are steered to 1 so the dividers never see 0.
   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, den_s, den_u;
   logic [31:0] mq, mr, sq, sr, uq, ur;
   logic        is_md, is_mul, div_zero;

   assign prod_s = {{32{x.A[31]}}, x.A} * {{32{x.B[31]}}, x.B};
   assign prod_u = {32'b0, x.A} * {32'b0, x.B};

   assign abs_a = x.A[31] ? (32'd0 - x.A) : x.A;
   assign abs_b = x.B[31] ? (32'd0 - x.B) : x.B;
   assign den_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
   assign den_u = (x.B == 32'd0) ? 32'd1 : x.B;
   assign mq    = abs_a / den_s;
   assign mr    = abs_a % den_s;
   assign sq    = (x.A[31] ^ x.B[31]) ? (32'd0 - mq) : mq;
   assign sr    = x.A[31] ? (32'd0 - mr) : mr;
   assign uq    = x.A / den_u;
   assign ur    = x.A % den_u;

   assign is_md    = (x.op >= OP_MULT) && (x.op <= OP_DIVU);
   assign is_mul   = (x.op == OP_MULT) || (x.op == OP_MULTU);
   assign div_zero = (x.B == 32'd0);

   assign x.busy       = (state_q == S_RUN);
   assign x.start      = is_md && (state_q == S_IDLE);
   assign x.stall_busy = x.start || x.busy;
   assign x.HI         = hi_q;
   assign x.LO         = lo_q;
   assign x.out        = (x.op == OP_MFHI) ? hi_q :
                         (x.op == OP_MFLO) ? lo_q : 32'd0;

   // Next-state: accept in IDLE, count down in RUN, commit on the last busy cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      case (state_q)
         S_IDLE: begin
            if (x.start) begin
               state_d = S_RUN;
               cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               case (x.op)
                  OP_MULT:  {phi_d, plo_d} = prod_s;
                  OP_MULTU: {phi_d, plo_d} = prod_u;
                  OP_DIV:   {phi_d, plo_d} = div_zero ? {hi_q, lo_q} : {sr, sq};
                  default:  {phi_d, plo_d} = div_zero ? {hi_q, lo_q} : {ur, uq};
               endcase
            end else if (x.op == OP_MTHI) begin
               hi_d = x.A;
            end else if (x.op == OP_MTLO) begin
               lo_d = x.A;
            end
         end
         default: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               hi_d    = phi_q;
               lo_d    = plo_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end
endmodule

// File: tb/tb_xalu.sv
// Directed self-checking bench for xalu: latency, arithmetic, HI/LO moves, ignores and async reset.
module tb_xalu;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   xalu_if xif ();

   xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .x     (xif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      xif.op = op;
      xif.A  = a;
      xif.B  = b;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(4'd0, 32'd0, 32'd0);
      #2;
      chk("rst_busy", 32'(xif.busy), 32'd0);
      chk("rst_hi", xif.HI, 32'd0);
      chk("rst_lo", xif.LO, 32'd0);
      chk("rst_out", xif.out, 32'd0);
      #10 reset = 1'b0;
      tick();

      // mult -3 * 5
      drive(4'd1, 32'hFFFF_FFFD, 32'd5);
      #1;
      chk("mult_start", 32'(xif.start), 32'd1);
      chk("mult_stall_T", 32'(xif.stall_busy), 32'd1);
      chk("mult_busy_T", 32'(xif.busy), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         drive(4'd0, 32'd0, 32'd0);
         #1;
         chk("mult_busy", 32'(xif.busy), 32'd1);
         chk("mult_stall", 32'(xif.stall_busy), 32'd1);
         if (k == 5) begin
            chk("mult_hi_early", xif.HI, 32'd0);
            chk("mult_lo_early", xif.LO, 32'd0);
         end
      end
      tick();
      chk("mult_busy_end", 32'(xif.busy), 32'd0);
      chk("mult_stall_end", 32'(xif.stall_busy), 32'd0);
      chk("mult_hi", xif.HI, 32'hFFFF_FFFF);
      chk("mult_lo", xif.LO, 32'hFFFF_FFF1);

      // multu back-to-back, then mfhi/mflo readback
      drive(4'd2, 32'hFFFF_FFFF, 32'd2);
      #1;
      chk("multu_start", 32'(xif.start), 32'd1);
      repeat (5) tick();
      drive(4'd0, 32'd0, 32'd0);
      tick();
      chk("multu_hi", xif.HI, 32'h0000_0001);
      chk("multu_lo", xif.LO, 32'hFFFF_FFFE);
      drive(4'd7, 32'd0, 32'd0);
      #1;
      chk("mfhi_out", xif.out, 32'h0000_0001);
      drive(4'd8, 32'd0, 32'd0);
      #1;
      chk("mflo_out", xif.out, 32'hFFFF_FFFE);
      drive(4'd0, 32'd0, 32'd0);
      #1;
      chk("none_out", xif.out, 32'd0);

      // div -7 / 2: busy must last exactly 10 cycles
      drive(4'd3, 32'hFFFF_FFF9, 32'd2);
      tick();
      drive(4'd0, 32'd0, 32'd0);
      repeat (9) tick();
      chk("div_busy_last", 32'(xif.busy), 32'd1);
      tick();
      chk("div_busy_end", 32'(xif.busy), 32'd0);
      chk("div_lo", xif.LO, 32'hFFFF_FFFD);
      chk("div_hi", xif.HI, 32'hFFFF_FFFF);

      // divu same operands
      drive(4'd4, 32'hFFFF_FFF9, 32'd2);
      tick();
      drive(4'd0, 32'd0, 32'd0);
      repeat (10) tick();
      chk("divu_lo", xif.LO, 32'h7FFF_FFFC);
      chk("divu_hi", xif.HI, 32'h0000_0001);

      // mthi, then divu by zero leaves HI/LO untouched
      drive(4'd5, 32'h0000_1234, 32'd0);
      tick();
      drive(4'd0, 32'd0, 32'd0);
      #1;
      chk("mthi_hi", xif.HI, 32'h0000_1234);
      drive(4'd4, 32'd7, 32'd0);
      tick();
      drive(4'd0, 32'd0, 32'd0);
      repeat (9) tick();
      chk("dz_busy_last", 32'(xif.busy), 32'd1);
      tick();
      chk("dz_busy_end", 32'(xif.busy), 32'd0);
      chk("dz_hi", xif.HI, 32'h0000_1234);
      chk("dz_lo", xif.LO, 32'h7FFF_FFFC);

      // mtlo and mult issued while busy are ignored
      drive(4'd1, 32'd2, 32'd3);
      tick();
      drive(4'd0, 32'd0, 32'd0);
      tick();
      drive(4'd6, 32'h0000_DEAD, 32'd0);
      #1;
      chk("ign_mtlo_start", 32'(xif.start), 32'd0);
      tick();
      chk("ign_mtlo_lo", xif.LO, 32'h7FFF_FFFC);
      drive(4'd1, 32'd9, 32'd9);
      #1;
      chk("ign_mult_start", 32'(xif.start), 32'd0);
      chk("ign_mult_stall", 32'(xif.stall_busy), 32'd1);
      tick();
      drive(4'd0, 32'd0, 32'd0);
      tick();
      tick();
      chk("ign_busy_end", 32'(xif.busy), 32'd0);
      chk("ign_lo", xif.LO, 32'd6);
      chk("ign_hi", xif.HI, 32'd0);

      // async reset in the middle of a divide
      drive(4'd3, 32'd100, 32'd7);
      tick();
      drive(4'd0, 32'd0, 32'd0);
      repeat (3) tick();
      chk("ar_busy_before", 32'(xif.busy), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      chk("ar_busy", 32'(xif.busy), 32'd0);
      chk("ar_hi", xif.HI, 32'd0);
      chk("ar_lo", xif.LO, 32'd0);
      drive(4'd1, 32'd1, 32'd1);
      #1;
      chk("ar_start_comb", 32'(xif.start), 32'd1);
      drive(4'd0, 32'd0, 32'd0);
      tick();
      reset = 1'b0;
      repeat (12) tick();
      chk("ar_busy_after", 32'(xif.busy), 32'd0);
      chk("ar_hi_after", xif.HI, 32'd0);
      chk("ar_lo_after", xif.LO, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
